piso_serializer: RTL and testbench



---
 rtl/piso_serializer_pkg.sv | 25 ++
 rtl/piso_serializer_if.sv | 16 +
 rtl/piso_serializer_bitcnt.sv | 28 ++
 rtl/piso_serializer.sv | 76 +++++++
 tb/tb_piso_serializer.sv | 131 +++++++++++++
 5 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared types and frame sizing for the PISO serializer.
// PISO_SERIALIZER_PARITY_EN appends an even-parity bit to every frame.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int unsigned frame_len(input int unsigned width);
`ifdef PISO_SERIALIZER_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(frame_len(width));
  endfunction

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial line of the PISO serializer.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] d;
  logic             load;
  logic             ready;
  logic             q;
  logic             frame;
  logic             last;

  modport master (output d, load, input ready, q, frame, last);
  modport slave  (input d, load, output ready, q, frame, last);

endinterface

// File: rtl/piso_serializer_bitcnt.sv
// Loadable down-counter for the bits left in a frame; tc marks the final bit.
module piso_bitcnt #(
  parameter int unsigned     CNT_W = 3,
  parameter logic [CNT_W-1:0] INIT = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic ld,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q;

  // Holds at zero so an idle serializer keeps the reset count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (ld) begin
      cnt_q <= INIT;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shifter: MSB first, back-to-back frames without gaps.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit after the LSB.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  piso_serializer_if.slave  bus
);

  localparam int unsigned FL = frame_len(WIDTH);
  localparam int unsigned CW = cnt_w(WIDTH);

  state_t          state_q;
  state_t          state_d;
  logic [FL-1:0]   sr_q;
  logic [FL-1:0]   frame_word;
  logic            tc;
  logic            last_w;
  logic            accept;

  assign last_w     = (state_q == SHIFT) && tc;
  assign bus.ready  = (state_q == IDLE) || last_w;
  assign accept     = bus.load && bus.ready;
  assign bus.frame  = (state_q == SHIFT);
  assign bus.q      = sr_q[FL-1];
  assign bus.last   = last_w;

`ifdef PISO_SERIALIZER_PARITY_EN
  assign frame_word = {bus.d, ^bus.d};
`else
  assign frame_word = bus.d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_w && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Zero fill leaves the register clear after a frame, so q idles low.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else if (accept) begin
      sr_q <= frame_word;
    end else if (state_q == SHIFT) begin
      sr_q <= {sr_q[FL-2:0], 1'b0};
    end
  end

  piso_bitcnt #(
    .CNT_W (CW),
    .INIT  (CW'(FL - 1))
  ) u_bitcnt (
    .clk (clk),
    .rst (rst),
    .ld  (accept),
    .en  (state_q == SHIFT),
    .tc  (tc)
  );

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer with WIDTH=8; honours PISO_SERIALIZER_PARITY_EN.
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  typedef struct packed {
    logic q;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_en = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb[$];

  piso_serializer_if #(.WIDTH(8)) bus ();

  piso_serializer #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic push_frame(input logic [7:0] dv);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.q    = dv[7-k];
      e.last = (k == FL - 1);
      sb.push_back(e);
    end
`ifdef PISO_SERIALIZER_PARITY_EN
    e.q    = ^dv;
    e.last = 1'b1;
    sb.push_back(e);
`endif
  endtask

  // One clock: drive inputs, predict acceptance, then record what the edge did.
  task automatic cycle(input logic ld, input logic [7:0] dv, input logic r);
    logic acc;
    bus.load = ld;
    bus.d    = dv;
    rst      = r;
    acc      = ld && bus.ready && !r;
    @(posedge clk);
    #1;
    if (r) sb.delete();
    if (acc) push_frame(dv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
  endtask

  // Monitor: {frame,q,last} must match the next queued bit, or idle when empty.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("line", {bus.frame, bus.q, bus.last}, {1'b1, e.q, e.last});
      end else begin
        chk("line_idle", {bus.frame, bus.q, bus.last}, 3'b000);
      end
    end
  end

  initial begin
    bus.load = 1'b0;
    bus.d    = 8'h00;

    // Reset held two cycles with load asserted: nothing accepted.
    cycle(1'b1, 8'hA5, 1'b1);
    cycle(1'b1, 8'hA5, 1'b1);
    chk("reset_outputs", {bus.frame, bus.q, bus.last}, 3'b000);
    chk("reset_ready", {2'b00, bus.ready}, 3'b001);
    chk("reset_no_accept", {2'b00, sb.size() == 0}, 3'b001);
    mon_en = 1'b1;

    // Single frame.
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'hA5, 1'b0);
    idle(FL + 2);

    // Back-to-back: 3C accepted on A5's last bit.
    cycle(1'b1, 8'hA5, 1'b0);
    idle(FL - 1);
    chk("b2b_last_ready", {1'b0, bus.last, bus.ready}, 3'b011);
    cycle(1'b1, 8'h3C, 1'b0);
    idle(FL + 2);

    // Load while busy is ignored until the last bit.
    cycle(1'b1, 8'hFF, 1'b0);
    for (int k = 1; k < FL; k++) begin
      chk("busy_ready", {2'b00, bus.ready}, 3'b000);
      cycle(k >= 2, 8'h00, 1'b0);
    end
    chk("busy_last_ready", {1'b0, bus.last, bus.ready}, 3'b011);
    cycle(1'b1, 8'h00, 1'b0);
    idle(FL + 2);

    // Reset after three bits; load right after reset is accepted.
    cycle(1'b1, 8'hA5, 1'b0);
    idle(2);
    cycle(1'b0, 8'h00, 1'b1);
    chk("midrst_outputs", {bus.frame, bus.q, bus.last}, 3'b000);
    chk("midrst_ready", {2'b00, bus.ready}, 3'b001);
    cycle(1'b1, 8'h07, 1'b0);
    idle(FL + 3);

    chk("sb_drain", {2'b00, sb.size() == 0}, 3'b001);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
